ps2_tx: RTL and testbench

- PS/2 device-side transmitter (keyboard emulator): serialises scan-code bytes onto ps2_clk/ps2_data, both generated from the system clock.
- Far end of the board's PS/2 keyboard receiver. Used to drive that receiver in simulation and loopback tests, and to replay scripted key sequences (e.g. make/break codes 0x1C, 0xF0 0x1C).
- Contains a small byte FIFO so a whole make/break sequence can be queued in one burst.

---
 rtl/ps2_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// Byte FIFO feeding the PS/2 transmitter; single clock, memory read is combinational at rd_ptr.
// Latency: a pushed byte is visible on rdat/count the cycle after the push edge.
// Backpressure: caller gates push with its own full check and pop with count != 0.
module ps2_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdat,
  input  logic          pop,
  output logic [W-1:0]  rdat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// PS/2 device-side transmitter: queues scan-code bytes and serialises 11-bit frames on ps2_clk/ps2_data.
// Latency: start bit appears two cycles after the byte is offered to an idle, empty transmitter.
// Backpressure: in_ready drops when the FIFO holds FIFO_DEPTH bytes; offers while low are dropped.
module ps2_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    shreg;
  logic [7:0]    fifo_rdat;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign push = in_valid && in_ready;
  assign pop  = (state == IDLE) && (fifo_count != '0);

  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + CW'(1);
    end else if (!push && pop) begin
      count_next = fifo_count - CW'(1);
    end
  end

  ps2_tx_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdat  (in_data),
    .pop   (pop),
    .rdat  (fifo_rdat),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
      half_cnt   <= '0;
      gap_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else begin
      // Registered view of the count after this edge; a same-cycle pop never frees a slot early.
      in_ready   <= (count_next != CW'(FIFO_DEPTH));
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          busy     <= (count_next != '0);
          if (pop) begin
            state    <= BIT_HI;
            ps2_data <= 1'b0;
            shreg    <= {1'b1, ~^fifo_rdat, fifo_rdat};
            bit_idx  <= '0;
            half_cnt <= HALF_LAST;
            busy     <= 1'b1;
          end
        end
        BIT_HI: begin
          busy <= 1'b1;
          if (half_cnt == '0) begin
            state    <= BIT_LO;
            ps2_clk  <= 1'b0;
            half_cnt <= HALF_LAST;
          end else begin
            half_cnt <= half_cnt - HW'(1);
          end
        end
        BIT_LO: begin
          busy <= 1'b1;
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - HW'(1);
          end else if (bit_idx < 4'd10) begin
            // Data only changes while the clock rises, keeping it stable around the falling edge.
            state    <= BIT_HI;
            ps2_clk  <= 1'b1;
            ps2_data <= shreg[0];
            shreg    <= {1'b0, shreg[9:1]};
            bit_idx  <= bit_idx + 4'd1;
            half_cnt <= HALF_LAST;
          end else begin
            state      <= GAP;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            gap_cnt    <= GAP_LAST;
            frame_done <= (GAP_CYCLES == 1);
          end
        end
        GAP: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= (count_next != '0);
          end else begin
            gap_cnt    <= gap_cnt - GW'(1);
            frame_done <= (gap_cnt == GW'(1));
            busy       <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: random and directed byte pushes, PS/2 receiver monitor and scoreboard.
module tb_ps2_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_LEN  = 22 * CLK_DIV + GAP_CYCLES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       frame_done;

  ps2_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int push_cyc = 0;
  int frames_rx = 0;
  int dones = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         start_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference frame straight from the PS/2 framing rules.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Receiver model: samples data on each ps2_clk falling edge.
  logic        in_frame = 1'b0;
  int          nbits = 0;
  int          run = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  logic [10:0] rx_bits = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      nbits    = 0;
      start_q.delete();
    end else begin
      if (frame_done) begin
        dones++;
        check("frame_done_pending", start_q.size() > 0, 1);
        if (start_q.size() > 0) check("frame_done_latency", cyc - start_q.pop_front(), FRAME_LEN - 1);
      end
      if (!in_frame) begin
        if (ps2_clk && prev_data && !ps2_data) begin
          in_frame = 1'b1;
          nbits    = 0;
          run      = 1;
          start_q.push_back(cyc);
          start_log.push_back(cyc);
        end
      end else if (ps2_clk != prev_clk) begin
        check(ps2_clk ? "low_phase_len" : "high_phase_len", run, CLK_DIV);
        run = 1;
        if (!ps2_clk && nbits < 11) begin
          check("data_stable_at_fall", ps2_data, prev_data);
          rx_bits[nbits] = ps2_data;
          nbits++;
          if (nbits == 11) begin
            frames_rx++;
            check("rx_parity_ok", ($countones(rx_bits[9:1]) % 2), 1);
            check("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("frame_bits", rx_bits, exp_frame(exp_q.pop_front()));
          end
        end else if (ps2_clk && nbits == 11) begin
          in_frame = 1'b0;
        end
      end else begin
        run++;
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic push(input logic [7:0] b, input logic exp_rdy);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    push_cyc = cyc;
    check("in_ready_at_push", in_ready, exp_rdy);
    if (exp_rdy) exp_q.push_back(b);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", n < budget, 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_start(input int n0);
    int n = 0;
    while (start_log.size() == n0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", start_log.size() > n0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int d0;
    int f0;
    int len;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Quiet idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {ps2_clk, ps2_data, busy, in_ready, frame_done}, 5'b11010);
    end

    // Single make code, start-bit latency.
    n0 = start_log.size();
    push(8'h1C, 1'b1);
    idle_cycle();
    wait_start(n0);
    if (start_log.size() > n0) check("start_latency", start_log[n0] - push_cyc, 2);
    wait_idle(200);

    // Break sequence on consecutive cycles: 97-cycle pitch, two done pulses.
    n0 = start_log.size();
    d0 = dones;
    push(8'hF0, 1'b1);
    push(8'h1C, 1'b1);
    idle_cycle();
    wait_idle(300);
    check("two_frames_started", start_log.size() - n0, 2);
    if (start_log.size() >= n0 + 2) check("frame_pitch", start_log[n0+1] - start_log[n0], FRAME_LEN + 1);
    check("two_done_pulses", dones - d0, 2);

    // Parity corner cases.
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    idle_cycle();
    wait_idle(300);

    // Random bursts that never fill the FIFO.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        push(8'($urandom_range(0, 255)), 1'b1);
        repeat ($urandom_range(0, 2)) idle_cycle();
      end
      idle_cycle();
      wait_idle(len * (FRAME_LEN + 1) + 100);
    end

    // Fill: nine back-to-back pushes accepted, tenth dropped.
    f0 = frames_rx;
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i * 7), i < 9);
    idle_cycle();
    wait_idle(9 * (FRAME_LEN + 1) + 100);
    check("fill_frame_count", frames_rx - f0, 9);

    // Reset during the low phase of data bit 3.
    push(8'hA5, 1'b1);
    idle_cycle();
    begin
      int n = 0;
      while (!(in_frame && nbits == 5) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reached_data_bit3", n < 200, 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_outputs", {ps2_clk, ps2_data, busy, in_ready, frame_done}, 5'b11010);
    f0 = frames_rx;
    push(8'h3C, 1'b1);
    idle_cycle();
    wait_idle(200);
    check("post_reset_frame", frames_rx - f0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
